// File: rtl/alu_ctrl.sv
// Command sequencer that owns an external combinational ALU and keeps an accumulator.
// A multiply is done by repeated addition through the ALU, one ADD per cycle.
module alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] acc,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        // Idle drive: LOAD code with zero operands whenever the ALU is not in use.
        alu_op  = OP_LOAD;
        alu_a   = '0;
        alu_b   = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    case (cmd_op)
                        OP_MUL: begin
                            cnt_d   = cmd_data;
                            prod_d  = '0;
                            mcand_d = acc_q;
                            state_d = ST_MUL;
                        end
                        OP_LOAD: begin
                            acc_d   = cmd_data;
                            state_d = ST_DONE;
                        end
                        OP_CLR: begin
                            acc_d   = '0;
                            state_d = ST_DONE;
                        end
                        default: state_d = ST_EXEC;
                    endcase
                end
            end
            ST_EXEC: begin
                alu_op  = op_q;
                alu_a   = acc_q;
                alu_b   = data_q;
                acc_d   = alu_result;
                state_d = ST_DONE;
            end
            ST_MUL: begin
                if (cnt_q != '0) begin
                    alu_op = OP_ADD;
                    alu_a  = prod_q;
                    alu_b  = mcand_q;
                    prod_d = alu_result;
                    cnt_d  = cnt_q - ONE;
                end else begin
                    acc_d   = prod_q;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign acc       = acc_q;
    assign zero      = (acc_q == '0);

endmodule

// File: tb/tb_alu_ctrl.sv
// Randomized bench for alu_ctrl with a behavioural ALU and an arithmetic accumulator model.
module tb_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [2:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic [7:0] acc;
    logic       zero;
    logic       busy;
    logic       done;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] model_acc;

    always #5 clk = ~clk;

    alu_ctrl #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .acc        (acc),
        .zero       (zero),
        .busy       (busy),
        .done       (done)
    );

    // Combinational ALU the controller drives.
    always_comb begin
        case (alu_op)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = ~alu_a;
            default: alu_result = alu_b;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d);
        int r;
        case (op)
            3'd0:    r = (int'(a) + int'(d)) % 256;
            3'd1:    r = (int'(a) - int'(d) + 256) % 256;
            3'd2:    r = int'(a & d);
            3'd3:    r = int'(a | d);
            3'd4:    r = 255 - int'(a);
            3'd5:    r = int'(d);
            3'd6:    r = (int'(a) * int'(d)) % 256;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [7:0] d);
        if (op <= 3'd4) return 2;
        if (op == 3'd6) return int'(d) + 2;
        return 1;
    endfunction

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] d);
        int         cyc;
        int         adds;
        int         waited;
        logic [7:0] acc_before;
        waited = 0;
        while (!cmd_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check_val("ready_wait", 32'(cmd_ready), 32'd1);
        acc_before = model_acc;
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_data   = d;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom);
        if (op <= 3'd4) begin
            check_val("exec_op", 32'(alu_op), 32'(op));
            check_val("exec_a", 32'(alu_a), 32'(acc_before));
            check_val("exec_b", 32'(alu_b), 32'(d));
        end
        cyc  = 1;
        adds = 0;
        while (!done && cyc < 400) begin
            if (alu_op == 3'b000) adds++;
            @(negedge clk);
            cyc++;
        end
        model_acc = ref_result(op, acc_before, d);
        check_val("latency", 32'(cyc), 32'(ref_latency(op, d)));
        check_val("done", 32'(done), 32'd1);
        check_val("acc", 32'(acc), 32'(model_acc));
        check_val("zero", 32'(zero), 32'(model_acc == 8'h00));
        if (op == 3'd6) check_val("mul_adds", 32'(adds), 32'(d));
        $display("cmd op=%0d data=0x%02h acc_in=0x%02h -> acc=0x%02h (model 0x%02h) latency=%0d",
                 op, d, acc_before, acc, model_acc, cyc);
        @(negedge clk);
        check_val("done_pulse", 32'(done), 32'd0);
        check_val("ready_after", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int         cyc;
        int         seen;
        logic [2:0] rop;
        logic [7:0] rd;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 8'h00;
        model_acc = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_acc", 32'(acc), 32'h0);
        check_val("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_acc", 32'(acc), 32'h0);
        check_val("idle_zero", 32'(zero), 32'd1);
        check_val("idle_ready", 32'(cmd_ready), 32'd1);
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("idle_done", 32'(done), 32'd0);
        check_val("idle_alu_op", 32'(alu_op), 32'h5);
        check_val("idle_alu_a", 32'(alu_a), 32'h0);
        check_val("idle_alu_b", 32'(alu_b), 32'h0);

        // Directed basic ops with known wrap results.
        run_cmd(3'd5, 8'h0F);
        run_cmd(3'd0, 8'hF5);
        check_val("add_wrap", 32'(acc), 32'h04);
        run_cmd(3'd1, 8'h05);
        check_val("sub_wrap", 32'(acc), 32'hFF);
        run_cmd(3'd2, 8'h3C);
        run_cmd(3'd3, 8'hC1);
        check_val("or_val", 32'(acc), 32'hFD);
        run_cmd(3'd4, 8'h00);
        check_val("not_val", 32'(acc), 32'h02);

        run_cmd(3'd5, 8'h07);
        run_cmd(3'd6, 8'h05);
        check_val("mul_7x5", 32'(acc), 32'h23);
        run_cmd(3'd5, 8'h10);
        run_cmd(3'd6, 8'h20);
        check_val("mul_wrap_zero", 32'(zero), 32'd1);
        run_cmd(3'd5, 8'h55);
        run_cmd(3'd6, 8'h00);
        check_val("mul_by_zero", 32'(acc), 32'h00);
        run_cmd(3'd7, 8'hAA);

        // Back-pressure: command held valid with changing data during a MUL.
        run_cmd(3'd5, 8'h06);
        cmd_valid = 1'b1;
        cmd_op    = 3'd6;
        cmd_data  = 8'h03;
        @(posedge clk);
        @(negedge clk);
        cmd_op = 3'd5;
        cyc    = 1;
        while (!done && cyc < 50) begin
            check_val("bp_ready_low", 32'(cmd_ready), 32'd0);
            cmd_data = 8'($urandom);
            @(negedge clk);
            cyc++;
        end
        model_acc = 8'h12;
        check_val("bp_latency", 32'(cyc), 32'd5);
        check_val("bp_mul_acc", 32'(acc), 32'h12);
        cmd_data = 8'hA5;
        @(negedge clk);
        check_val("bp_no_early_accept", 32'(acc), 32'h12);
        check_val("bp_ready_idle", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_val("bp_load_done", 32'(done), 32'd1);
        check_val("bp_load_acc", 32'(acc), 32'hA5);
        model_acc = 8'hA5;
        $display("cmd held-valid LOAD after MUL -> acc=0x%02h", acc);
        @(negedge clk);

        // Reset during the third MUL iteration.
        run_cmd(3'd5, 8'h03);
        cmd_valid = 1'b1;
        cmd_op    = 3'd6;
        cmd_data  = 8'h09;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("mid_mul_op", 32'(alu_op), 32'h0);
        rst_n = 1'b0;
        #1;
        check_val("abort_acc", 32'(acc), 32'h0);
        check_val("abort_zero", 32'(zero), 32'd1);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_ready", 32'(cmd_ready), 32'd1);
        check_val("abort_alu_op", 32'(alu_op), 32'h5);
        @(negedge clk);
        rst_n     = 1'b1;
        model_acc = 8'h00;
        seen      = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        check_val("abort_no_done", 32'(seen), 32'd0);
        $display("cmd reset mid-MUL -> acc=0x%02h", acc);
        run_cmd(3'd5, 8'h11);

        // Randomized commands, then a worst-case multiplier.
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 7));
            rd  = (rop == 3'd6) ? 8'($urandom_range(0, 40)) : 8'($urandom);
            run_cmd(rop, rd);
        end
        run_cmd(3'd5, 8'($urandom));
        run_cmd(3'd6, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
